// File: rtl/pipelined_block_adder.sv
// Pipelined carry-lookahead adder/subtractor: one register stage per BLOCK-bit lookahead block,
// with a block carry registered between stages and a global valid/ready stall.
module pipelined_block_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int unsigned NB = WIDTH / BLOCK;
    // Block result layout: {carry out, carry into block MSB, BLOCK sum bits}
    localparam int unsigned RW = BLOCK + 2;

    if (BLOCK < 1 || BLOCK > 16 || WIDTH == 0 || (WIDTH % BLOCK) != 0) begin : g_param_check
        $error("pipelined_block_adder: WIDTH must be a positive multiple of BLOCK and BLOCK in 1..16");
    end

    // Full lookahead: every carry is a flat sum of products of g/p and the block carry-in.
    function automatic logic [RW-1:0] cla_block(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             cin
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             term;
        g    = a & b;
        p    = a | b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(BLOCK); i++) begin
            term = cin;
            for (int m = 0; m <= i; m++) begin
                term = term & p[m];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[BLOCK], c[BLOCK-1], a ^ b ^ c[BLOCK-1:0]};
    endfunction

    // Stage registers. a/b hold the not-yet-summed operand bits shifted down to bit 0;
    // s holds finished sum blocks shifted in from the top so the last stage is in place.
    logic [WIDTH-1:0] a_q [NB];
    logic [WIDTH-1:0] a_d [NB];
    logic [WIDTH-1:0] b_q [NB];
    logic [WIDTH-1:0] b_d [NB];
    logic [WIDTH-1:0] s_q [NB];
    logic [WIDTH-1:0] s_d [NB];
    logic [NB-1:0]    c_q;
    logic [NB-1:0]    c_d;
    logic [NB-1:0]    v_q;
    logic [NB-1:0]    v_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             zero_q;
    logic             zero_d;

    logic [WIDTH-1:0] src_a [NB];
    logic [WIDTH-1:0] src_b [NB];
    logic [WIDTH-1:0] src_s [NB];
    logic [NB-1:0]    src_c;
    logic [NB-1:0]    src_v;
    logic [RW-1:0]    res   [NB];
    logic             adv;

    always_comb begin
        adv = ~reset & (~v_q[NB-1] | out_ready);
    end

    // Stage inputs: stage 0 sees the prepared operands, stage k sees register k-1.
    always_comb begin
        src_a[0] = in_a;
        src_b[0] = in_sub ? ~in_b : in_b;
        src_s[0] = '0;
        src_c    = '0;
        src_v    = '0;
        src_c[0] = in_sub | in_cin;
        src_v[0] = in_valid;
        for (int k = 1; k < int'(NB); k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
            src_v[k] = v_q[k-1];
        end
    end

    // Per-stage block add and skew shift; flags come from the last block only.
    always_comb begin
        c_d = '0;
        v_d = '0;
        for (int k = 0; k < int'(NB); k++) begin
            res[k] = cla_block(src_a[k][BLOCK-1:0], src_b[k][BLOCK-1:0], src_c[k]);
            a_d[k] = src_a[k] >> BLOCK;
            b_d[k] = src_b[k] >> BLOCK;
            s_d[k] = (src_s[k] >> BLOCK) | (WIDTH'(res[k][BLOCK-1:0]) << (WIDTH - BLOCK));
            c_d[k] = res[k][BLOCK+1];
            v_d[k] = src_v[k];
        end
        ovf_d  = res[NB-1][BLOCK+1] ^ res[NB-1][BLOCK];
        zero_d = ~|s_d[NB-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < int'(NB); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            c_q    <= '0;
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            c_q    <= c_d;
            v_q    <= v_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = v_q[NB-1];
    assign out_sum   = s_q[NB-1];
    assign out_cout  = c_q[NB-1];
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_pipelined_block_adder.sv
// Directed bench for pipelined_block_adder (32/8) plus random sweeps on 16/4 and 8/8 instances.
module tb_pipelined_block_adder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        in_valid, in_ready, in_cin, in_sub;
    logic        out_valid, out_ready, out_cout, out_ovf, out_zero;
    logic [31:0] in_a, in_b, out_sum;

    logic        w16_in_valid, w16_in_ready, w16_in_cin, w16_in_sub;
    logic        w16_out_valid, w16_out_ready, w16_out_cout, w16_out_ovf, w16_out_zero;
    logic [15:0] w16_in_a, w16_in_b, w16_out_sum;

    logic        w8_in_valid, w8_in_ready, w8_in_cin, w8_in_sub;
    logic        w8_out_valid, w8_out_ready, w8_out_cout, w8_out_ovf, w8_out_zero;
    logic [7:0]  w8_in_a, w8_in_b, w8_out_sum;

    int checks   = 0;
    int failures = 0;

    pipelined_block_adder #(.WIDTH(32), .BLOCK(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    pipelined_block_adder #(.WIDTH(16), .BLOCK(4)) dut16 (
        .clock(clock), .reset(reset),
        .in_valid(w16_in_valid), .in_ready(w16_in_ready), .in_a(w16_in_a), .in_b(w16_in_b),
        .in_cin(w16_in_cin), .in_sub(w16_in_sub),
        .out_valid(w16_out_valid), .out_ready(w16_out_ready), .out_sum(w16_out_sum),
        .out_cout(w16_out_cout), .out_ovf(w16_out_ovf), .out_zero(w16_out_zero)
    );

    pipelined_block_adder #(.WIDTH(8), .BLOCK(8)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(w8_in_valid), .in_ready(w8_in_ready), .in_a(w8_in_a), .in_b(w8_in_b),
        .in_cin(w8_in_cin), .in_sub(w8_in_sub),
        .out_valid(w8_out_valid), .out_ready(w8_out_ready), .out_sum(w8_out_sum),
        .out_cout(w8_out_cout), .out_ovf(w8_out_ovf), .out_zero(w8_out_zero)
    );

    // Reference arithmetic for the sweeps: {sum, cout, ovf, zero}
    function automatic logic [18:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic sub);
        logic [15:0] bp;
        logic [16:0] ext;
        logic        ovf;
        bp  = sub ? ~b : b;
        ext = {1'b0, a} + {1'b0, bp} + 17'(sub ? 1'b1 : cin);
        ovf = (a[15] == bp[15]) && (ext[15] != a[15]);
        return {ext[15:0], ext[16], ovf, ext[15:0] == 16'h0};
    endfunction

    function automatic logic [10:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic sub);
        logic [7:0] bp;
        logic [8:0] ext;
        logic       ovf;
        bp  = sub ? ~b : b;
        ext = {1'b0, a} + {1'b0, bp} + 9'(sub ? 1'b1 : cin);
        ovf = (a[7] == bp[7]) && (ext[7] != a[7]);
        return {ext[7:0], ext[8], ovf, ext[7:0] == 8'h0};
    endfunction

    // Sends one beat into an empty pipe, waits (bounded) for its result, then retires it.
    task automatic run_one(input logic [31:0] a, input logic [31:0] b, input logic cin,
                           input logic sub, output logic [31:0] s, output logic c,
                           output logic o, output logic z, output int lat);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        s = out_sum; c = out_cout; o = out_ovf; z = out_zero;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== 36'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h",
                     {out_valid, out_sum, out_cout, out_ovf, out_zero}, 36'h0);
        end
        checks++;
        if ({w16_out_valid, w16_out_sum, w8_out_valid, w8_out_sum} !== 26'h0) begin
            failures++;
            $display("FAIL reset_sweep_duts got=%h exp=0",
                     {w16_out_valid, w16_out_sum, w8_out_valid, w8_out_sum});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_carry_chain();
        logic [31:0] s; logic c, o, z; int lat;
        run_one(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, s, c, o, z, lat);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL carry_latency got=%0d exp=4", lat); end
        checks++;
        if (s !== 32'h0) begin failures++; $display("FAIL carry_sum got=%h exp=00000000", s); end
        checks++;
        if ({c, o, z} !== 3'b101) begin
            failures++; $display("FAIL carry_flags cout/ovf/zero got=%b exp=101", {c, o, z});
        end
    endtask

    task automatic test_add_overflow();
        logic [31:0] s; logic c, o, z; int lat;
        run_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, s, c, o, z, lat);
        checks++;
        if (s !== 32'h8000_0000) begin failures++; $display("FAIL addovf_sum got=%h exp=80000000", s); end
        checks++;
        if ({c, o, z} !== 3'b010) begin
            failures++; $display("FAIL addovf_flags cout/ovf/zero got=%b exp=010", {c, o, z});
        end
    endtask

    task automatic test_subtract();
        logic [31:0] s; logic c, o, z; int lat;
        run_one(32'd5, 32'd7, 1'b1, 1'b1, s, c, o, z, lat);
        checks++;
        if (s !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_sum got=%h exp=fffffffe", s); end
        checks++;
        if ({c, o, z} !== 3'b000) begin
            failures++; $display("FAIL sub_flags cout/ovf/zero got=%b exp=000", {c, o, z});
        end
        run_one(32'h8000_0000, 32'h1, 1'b0, 1'b1, s, c, o, z, lat);
        checks++;
        if (s !== 32'h7FFF_FFFF) begin failures++; $display("FAIL subovf_sum got=%h exp=7fffffff", s); end
        checks++;
        if ({c, o, z} !== 3'b110) begin
            failures++; $display("FAIL subovf_flags cout/ovf/zero got=%b exp=110", {c, o, z});
        end
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          got = 0;
        logic [31:0] q[$];
        logic        stalled_prev = 1'b0;
        logic [35:0] prev_out = '0;
        logic        exp_rdy;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            exp_rdy   = !(cyc >= 5 && cyc <= 7);
            if (sent < 8) begin
                in_valid = 1'b1; in_a = 32'(sent); in_b = 32'(sent * 16);
                in_cin = 1'b0; in_sub = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (stalled_prev) begin
                checks++;
                if ({out_valid, out_sum, out_cout, out_ovf, out_zero} !== prev_out) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got=%h exp=%h", cyc,
                             {out_valid, out_sum, out_cout, out_ovf, out_zero}, prev_out);
                end
            end
            checks++;
            if (in_ready !== exp_rdy) begin
                failures++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy);
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL stream_extra cyc=%0d got=%h exp=none", cyc, out_sum);
                end else begin
                    if (out_sum !== q[0]) begin
                        failures++; $display("FAIL stream_sum cyc=%0d got=%h exp=%h", cyc, out_sum, q[0]);
                    end
                    void'(q.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(32'(sent * 17));
                sent++;
            end
            stalled_prev = out_valid && !out_ready;
            prev_out     = {out_valid, out_sum, out_cout, out_ovf, out_zero};
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (got !== 8 || q.size() !== 0) begin
            failures++; $display("FAIL stream_count got=%0d exp=8 pending=%0d", got, q.size());
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] s; logic c, o, z; int lat; int seen;
        out_ready = 1'b1; in_cin = 1'b0; in_sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 32'(i + 1); in_b = 32'(i + 1);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("FAIL midreset_in_ready got=%b exp=0", in_ready); end
        @(posedge clock); #1;
        reset = 1'b0;
        seen  = 0;
        repeat (6) begin
            if (out_valid) seen++;
            @(posedge clock); #1;
        end
        checks++;
        if (seen !== 0) begin failures++; $display("FAIL midreset_discard got=%0d valid cycles exp=0", seen); end
        run_one(32'd1, 32'd2, 1'b0, 1'b0, s, c, o, z, lat);
        checks++;
        if (s !== 32'd3 || lat !== 4) begin
            failures++; $display("FAIL midreset_after got=%h lat=%0d exp=00000003 lat=4", s, lat);
        end
    endtask

    task automatic test_param_sweep();
        logic [18:0] q16[$];
        logic [10:0] q8[$];
        int sent16 = 0, got16 = 0, sent8 = 0, got8 = 0;
        for (int cyc = 0; cyc < 20000 && (got16 < 1000 || got8 < 1000); cyc++) begin
            w16_in_valid  = (sent16 < 1000) && ($urandom_range(3) != 0);
            w16_in_a      = 16'($urandom); w16_in_b = 16'($urandom);
            w16_in_cin    = 1'($urandom);  w16_in_sub = 1'($urandom);
            w16_out_ready = ($urandom_range(2) != 0);
            w8_in_valid   = (sent8 < 1000) && ($urandom_range(3) != 0);
            w8_in_a       = 8'($urandom);  w8_in_b = 8'($urandom);
            w8_in_cin     = 1'($urandom);  w8_in_sub = 1'($urandom);
            w8_out_ready  = ($urandom_range(2) != 0);
            #1;
            if (w16_out_valid && w16_out_ready) begin
                checks++;
                if (q16.size() == 0) begin
                    failures++; $display("FAIL sweep16_extra got=%h exp=none", w16_out_sum);
                end else begin
                    if ({w16_out_sum, w16_out_cout, w16_out_ovf, w16_out_zero} !== q16[0]) begin
                        failures++;
                        $display("FAIL sweep16 got=%h exp=%h",
                                 {w16_out_sum, w16_out_cout, w16_out_ovf, w16_out_zero}, q16[0]);
                    end
                    void'(q16.pop_front());
                end
                got16++;
            end
            if (w8_out_valid && w8_out_ready) begin
                checks++;
                if (q8.size() == 0) begin
                    failures++; $display("FAIL sweep8_extra got=%h exp=none", w8_out_sum);
                end else begin
                    if ({w8_out_sum, w8_out_cout, w8_out_ovf, w8_out_zero} !== q8[0]) begin
                        failures++;
                        $display("FAIL sweep8 got=%h exp=%h",
                                 {w8_out_sum, w8_out_cout, w8_out_ovf, w8_out_zero}, q8[0]);
                    end
                    void'(q8.pop_front());
                end
                got8++;
            end
            if (w16_in_valid && w16_in_ready) begin
                q16.push_back(ref16(w16_in_a, w16_in_b, w16_in_cin, w16_in_sub));
                sent16++;
            end
            if (w8_in_valid && w8_in_ready) begin
                q8.push_back(ref8(w8_in_a, w8_in_b, w8_in_cin, w8_in_sub));
                sent8++;
            end
            @(posedge clock); #1;
        end
        w16_in_valid = 1'b0; w8_in_valid = 1'b0;
        checks++;
        if (got16 !== 1000) begin failures++; $display("FAIL sweep16_count got=%0d exp=1000", got16); end
        checks++;
        if (got8 !== 1000) begin failures++; $display("FAIL sweep8_count got=%0d exp=1000", got8); end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
        w16_in_valid = 1'b0; w16_in_a = '0; w16_in_b = '0; w16_in_cin = 1'b0; w16_in_sub = 1'b0;
        w16_out_ready = 1'b1;
        w8_in_valid = 1'b0; w8_in_a = '0; w8_in_b = '0; w8_in_cin = 1'b0; w8_in_sub = 1'b0;
        w8_out_ready = 1'b1;
        test_reset();
        test_carry_chain();
        test_add_overflow();
        test_subtract();
        test_back_to_back();
        test_mid_reset();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
